// File: rtl/fast_pkg.sv
// Shared definitions for the FAST packet receive path: word markers, error bits,
// deframer states and the descriptor layout.
package fast_pkg;

  localparam logic [1:0] FAST_HEAD = 2'b01;
  localparam logic [1:0] FAST_BODY = 2'b00;
  localparam logic [1:0] FAST_TAIL = 2'b10;
  localparam logic [1:0] FAST_SOLE = 2'b11;

  localparam int ERR_OVF   = 0;
  localparam int ERR_TRUNC = 1;
  localparam int ERR_LONG  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_OVF  = 2'd2,
    ST_DISC = 2'd3
  } state_t;

  typedef struct packed {
    logic [6:0]  words;
    logic [10:0] bytes;
    logic [2:0]  err;
  } desc_t;

  // 11-bit wrap is intentional: the descriptor field is only 11 bits wide.
  function automatic logic [10:0] pkt_bytes(input logic [6:0] words, input logic [3:0] inv);
    return {words, 4'b0000} - {7'b0, inv};
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; dout reads as zero while empty so
// downstream sees clean outputs after reset.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic             do_wr, do_rd;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;
  assign dout  = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= din;
  end

endmodule

// File: rtl/fast_pkt_rx.sv
// FAST packet receive deframer: stores admitted words in a data FIFO, emits one
// descriptor per packet and keeps accepted/dropped/errored packet counters.
module fast_pkt_rx
  import fast_pkg::*;
#(
  parameter int DATA_AW   = 5,
  parameter int DESC_AW   = 3,
  parameter int MAX_WORDS = 96
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         dataIn_valid_i,
  input  logic [133:0] dataIn_i,
  output logic         data_valid_o,
  output logic [133:0] data_o,
  input  logic         data_rd_i,
  output logic         desc_valid_o,
  output logic [6:0]   desc_words_o,
  output logic [10:0]  desc_bytes_o,
  output logic [2:0]   desc_err_o,
  input  logic         desc_rd_i,
  output logic [31:0]  pkt_cnt_o,
  output logic [31:0]  drop_cnt_o,
  output logic [31:0]  err_cnt_o
);
  localparam int DESC_DEPTH = 1 << DESC_AW;

  state_t state, state_nx, head_nx;
  logic [6:0] wcnt;
  logic [2:0] err_acc;
  logic [DESC_AW:0] desc_occ;
  desc_t pend, desc_din, desc_dout, a_desc, b_desc;
  logic pend_vld, a_vld, b_vld, desc_wr, desc_pop;
  logic data_full, data_empty, desc_full, desc_empty;
  logic store, start, wc_inc, drop_inc;
  logic [2:0] err_set;
  logic [1:0] mk;
  logic [3:0] inv;
  logic w_head, w_tail, w_sole, open_pkt, admit, at_max;

  assign mk       = dataIn_i[133:132];
  assign inv      = dataIn_i[131:128];
  assign w_head   = dataIn_valid_i & mk[0];
  assign w_sole   = dataIn_valid_i & (mk == FAST_SOLE);
  assign w_tail   = dataIn_valid_i & (mk == FAST_TAIL);
  assign open_pkt = (state == ST_RECV) || (state == ST_OVF);
  assign at_max   = (wcnt == 7'(MAX_WORDS));

  // desc_occ counts FIFO entries plus the pending one; a head that closes an
  // open packet in the same cycle needs room for both descriptors.
  assign admit   = ~data_full &&
                   ((int'(desc_occ) + int'(open_pkt & w_head)) < DESC_DEPTH);
  assign head_nx = w_sole ? ST_IDLE : (admit ? ST_RECV : ST_DISC);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (w_head) state_nx = head_nx;
    else begin
      case (state)
        ST_RECV: begin
          if (dataIn_valid_i && (data_full || at_max)) state_nx = w_tail ? ST_IDLE : ST_OVF;
          else if (w_tail)                             state_nx = ST_IDLE;
        end
        ST_OVF, ST_DISC: if (w_tail) state_nx = ST_IDLE;
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    store    = 1'b0;
    start    = 1'b0;
    wc_inc   = 1'b0;
    drop_inc = 1'b0;
    err_set  = '0;
    a_vld    = 1'b0;
    a_desc   = '0;
    b_vld    = 1'b0;
    b_desc   = '0;
    if (w_head) begin
      if (admit) begin
        store = 1'b1;
        if (w_sole) begin
          b_vld  = 1'b1;
          b_desc = '{words: 7'd1, bytes: pkt_bytes(7'd1, inv), err: 3'b000};
        end else start = 1'b1;
      end else drop_inc = 1'b1;
    end
    case (state)
      ST_IDLE: if (w_tail) drop_inc = 1'b1;
      ST_RECV: begin
        if (w_head) begin
          a_vld  = 1'b1;
          a_desc = '{words: wcnt, bytes: pkt_bytes(wcnt, 4'd0), err: err_acc | 3'b010};
        end else if (dataIn_valid_i && (data_full || at_max)) begin
          err_set = {at_max, 1'b0, data_full};
          // A tail that cannot be stored still closes the packet.
          if (w_tail) begin
            a_vld  = 1'b1;
            a_desc = '{words: wcnt, bytes: pkt_bytes(wcnt, 4'd0), err: err_acc | err_set};
          end
        end else if (dataIn_valid_i) begin
          store  = 1'b1;
          wc_inc = 1'b1;
          if (w_tail) begin
            a_vld  = 1'b1;
            a_desc = '{words: 7'(wcnt + 7'd1), bytes: pkt_bytes(7'(wcnt + 7'd1), inv), err: err_acc};
          end
        end
      end
      ST_OVF: begin
        if (w_head) begin
          a_vld  = 1'b1;
          a_desc = '{words: wcnt, bytes: pkt_bytes(wcnt, 4'd0), err: err_acc | 3'b010};
        end else if (w_tail) begin
          a_vld  = 1'b1;
          a_desc = '{words: wcnt, bytes: pkt_bytes(wcnt, 4'd0), err: err_acc};
        end
      end
      default: ;
    endcase
  end

  // A head+tail that closes an open packet yields two descriptors in one cycle;
  // the second waits one cycle in pend. Order is pend, then close, then sole.
  assign desc_wr  = pend_vld | a_vld | b_vld;
  assign desc_din = pend_vld ? pend : (a_vld ? a_desc : b_desc);
  assign desc_pop = desc_rd_i & ~desc_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_vld  <= 1'b0;
      pend      <= '0;
      desc_occ  <= '0;
      wcnt      <= '0;
      err_acc   <= '0;
      pkt_cnt_o <= '0;
      drop_cnt_o <= '0;
      err_cnt_o <= '0;
    end else begin
      if (pend_vld) begin
        pend_vld <= a_vld | b_vld;
        pend     <= a_vld ? a_desc : b_desc;
      end else begin
        pend_vld <= a_vld & b_vld;
        pend     <= b_desc;
      end
      desc_occ <= desc_occ + (DESC_AW+1)'(a_vld) + (DESC_AW+1)'(b_vld) - (DESC_AW+1)'(desc_pop);
      if (start) begin
        wcnt    <= 7'd1;
        err_acc <= '0;
      end else begin
        if (wc_inc) wcnt <= wcnt + 7'd1;
        err_acc <= err_acc | err_set;
      end
      if (desc_wr)                         pkt_cnt_o  <= pkt_cnt_o + 32'd1;
      if (desc_wr && desc_din.err != 3'b0) err_cnt_o  <= err_cnt_o + 32'd1;
      if (drop_inc)                        drop_cnt_o <= drop_cnt_o + 32'd1;
    end
  end

  sync_fifo_fwft #(.WIDTH(134), .AW(DATA_AW)) u_data_fifo (
    .clk    (clk),
    .resetn (resetn),
    .wr     (store),
    .din    (dataIn_i),
    .full   (data_full),
    .rd     (data_rd_i),
    .dout   (data_o),
    .empty  (data_empty)
  );

  sync_fifo_fwft #(.WIDTH($bits(desc_t)), .AW(DESC_AW)) u_desc_fifo (
    .clk    (clk),
    .resetn (resetn),
    .wr     (desc_wr),
    .din    (desc_din),
    .full   (desc_full),
    .rd     (desc_rd_i),
    .dout   (desc_dout),
    .empty  (desc_empty)
  );

  assign data_valid_o = ~data_empty;
  assign desc_valid_o = ~desc_empty;
  assign desc_words_o = desc_dout.words;
  assign desc_bytes_o = desc_dout.bytes;
  assign desc_err_o   = desc_dout.err;

  logic unused;
  assign unused = desc_full;

endmodule

// File: tb/tb_fast_pkt_rx.sv
// Bench for fast_pkt_rx: word/descriptor table plus scoreboard queues drained by
// a reader process, and hand sequences for latency, overflow and mid-packet reset.
module tb_fast_pkt_rx;
  import fast_pkg::*;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         dataIn_valid_i = 1'b0;
  logic [133:0] dataIn_i = '0;
  logic         data_valid_o, desc_valid_o;
  logic [133:0] data_o;
  logic         data_rd_i = 1'b0, desc_rd_i = 1'b0;
  logic [6:0]   desc_words_o;
  logic [10:0]  desc_bytes_o;
  logic [2:0]   desc_err_o;
  logic [31:0]  pkt_cnt_o, drop_cnt_o, err_cnt_o;

  always #5 clk = ~clk;

  fast_pkt_rx dut (
    .clk(clk), .resetn(resetn),
    .dataIn_valid_i(dataIn_valid_i), .dataIn_i(dataIn_i),
    .data_valid_o(data_valid_o), .data_o(data_o), .data_rd_i(data_rd_i),
    .desc_valid_o(desc_valid_o), .desc_words_o(desc_words_o),
    .desc_bytes_o(desc_bytes_o), .desc_err_o(desc_err_o), .desc_rd_i(desc_rd_i),
    .pkt_cnt_o(pkt_cnt_o), .drop_cnt_o(drop_cnt_o), .err_cnt_o(err_cnt_o)
  );

  typedef struct {
    bit          vld;
    logic [1:0]  mk;
    logic [3:0]  inv;
    bit          st;
    bit          dv;
    logic [6:0]  w;
    logic [10:0] b;
    logic [2:0]  e;
    bit          dr;
  } vec_t;

  vec_t         tab[$];
  logic [133:0] dq[$];
  logic [20:0]  descq[$];
  int nchk = 0, nmis = 0;
  int exp_pkt = 0, exp_drop = 0, exp_err = 0;
  bit rd_en = 1'b1;

  function automatic vec_t V(input logic [1:0] mk, input logic [3:0] inv, input bit st,
                             input bit dv = 0, input logic [6:0] w = 0,
                             input logic [10:0] b = 0, input logic [2:0] e = 0,
                             input bit dr = 0);
    vec_t r;
    r.vld = 1'b1; r.mk = mk; r.inv = inv; r.st = st;
    r.dv = dv; r.w = w; r.b = b; r.e = e; r.dr = dr;
    return r;
  endfunction

  // Idle cycle carrying a descriptor expectation (second descriptor of a cycle).
  function automatic vec_t I(input logic [6:0] w, input logic [10:0] b, input logic [2:0] e);
    vec_t r;
    r = V(FAST_BODY, 4'd0, 1'b0, 1'b1, w, b, e);
    r.vld = 1'b0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
    nchk++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    dataIn_valid_i = v.vld;
    dataIn_i = {v.mk, v.inv, $urandom, $urandom, $urandom, $urandom};
    if (v.st) dq.push_back(dataIn_i);
    if (v.dv) begin
      descq.push_back({v.w, v.b, v.e});
      exp_pkt++;
      if (v.e != 3'b0) exp_err++;
    end
    if (v.dr) exp_drop++;
  endtask

  task automatic idle();
    @(negedge clk);
    dataIn_valid_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 400 && (dq.size() != 0 || descq.size() != 0); i++) @(negedge clk);
    if (dq.size() != 0 || descq.size() != 0) begin
      nchk++; nmis++;
      $display("FAIL %s_timeout: %0d words %0d descs outstanding, required 0", nm, dq.size(), descq.size());
    end
    @(negedge clk);
    chk({nm, "_data_empty"}, data_valid_o, 0);
    chk({nm, "_desc_empty"}, desc_valid_o, 0);
  endtask

  task automatic chk_cnt(input string nm);
    chk({nm, "_pkt_cnt"}, pkt_cnt_o, exp_pkt);
    chk({nm, "_drop_cnt"}, drop_cnt_o, exp_drop);
    chk({nm, "_err_cnt"}, err_cnt_o, exp_err);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_data_valid"}, data_valid_o, 0);
    chk({nm, "_data_o"}, data_o, 0);
    chk({nm, "_desc_valid"}, desc_valid_o, 0);
    chk({nm, "_desc"}, {desc_words_o, desc_bytes_o, desc_err_o}, 0);
    chk_cnt(nm);
  endtask

  // Reader: pops whatever the DUT presents and compares against the scoreboard.
  always @(negedge clk) begin
    data_rd_i = 1'b0;
    desc_rd_i = 1'b0;
    if (resetn && rd_en && data_valid_o) begin
      if (dq.size() == 0) begin
        nchk++; nmis++;
        $display("FAIL data_unexpected: got %h required no word", data_o);
      end else chk("data_word", data_o, dq.pop_front());
      data_rd_i = 1'b1;
    end
    if (resetn && rd_en && desc_valid_o) begin
      if (descq.size() == 0) begin
        nchk++; nmis++;
        $display("FAIL desc_unexpected: got w=%0d b=%0d e=%b required none", desc_words_o, desc_bytes_o, desc_err_o);
      end else chk("desc", {desc_words_o, desc_bytes_o, desc_err_o}, descq.pop_front());
      desc_rd_i = 1'b1;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(negedge clk);
    resetn = 1'b1;

    // 4-word packet, tail invalid 3
    tab.push_back(V(FAST_HEAD, 0, 1));
    tab.push_back(V(FAST_BODY, 0, 1));
    tab.push_back(V(FAST_BODY, 0, 1));
    tab.push_back(V(FAST_TAIL, 3, 1, 1, 4, 61, 3'b000));
    // single-word packet
    tab.push_back(V(FAST_SOLE, 0, 1, 1, 1, 16, 3'b000));
    // head before tail truncates the first packet
    tab.push_back(V(FAST_HEAD, 0, 1));
    tab.push_back(V(FAST_BODY, 0, 1));
    tab.push_back(V(FAST_HEAD, 0, 1, 1, 2, 32, 3'b010));
    tab.push_back(V(FAST_TAIL, 0, 1, 1, 2, 32, 3'b000));
    // orphans in IDLE, then a clean packet
    tab.push_back(V(FAST_BODY, 0, 0));
    tab.push_back(V(FAST_TAIL, 0, 0, 0, 0, 0, 0, 1));
    tab.push_back(V(FAST_HEAD, 0, 1));
    tab.push_back(V(FAST_TAIL, 5, 1, 1, 2, 27, 3'b000));
    // head+tail closing an open packet: two descriptors back to back
    tab.push_back(V(FAST_HEAD, 0, 1));
    tab.push_back(V(FAST_BODY, 0, 1));
    tab.push_back(V(FAST_SOLE, 2, 1, 1, 2, 32, 3'b010));
    tab.push_back(I(1, 14, 3'b000));
    // 98-word packet: 96 stored, the rest dropped with LONG
    tab.push_back(V(FAST_HEAD, 0, 1));
    for (int i = 0; i < 95; i++) tab.push_back(V(FAST_BODY, 0, 1));
    tab.push_back(V(FAST_BODY, 0, 0));
    tab.push_back(V(FAST_TAIL, 7, 0, 1, 96, 1536, 3'b100));

    foreach (tab[i]) drive(tab[i]);
    idle();
    drain("table");
    chk_cnt("table");

    // descriptor visible one cycle after a single-word packet
    drive(V(FAST_SOLE, 0, 1, 1, 1, 16, 3'b000));
    @(posedge clk); #1;
    chk("sole_desc_latency", desc_valid_o, 1);
    chk("sole_data_latency", data_valid_o, 1);
    idle();
    drain("sole");

    // data FIFO overflow with no reads, then a head refused for lack of space
    rd_en = 1'b0;
    drive(V(FAST_HEAD, 0, 1));
    for (int i = 0; i < 31; i++) drive(V(FAST_BODY, 0, 1));
    drive(V(FAST_BODY, 0, 0));
    drive(V(FAST_BODY, 0, 0));
    drive(V(FAST_TAIL, 0, 0, 1, 32, 512, 3'b001));
    drive(V(FAST_HEAD, 0, 0, 0, 0, 0, 0, 1));
    drive(V(FAST_BODY, 0, 0));
    drive(V(FAST_TAIL, 0, 0));
    idle();
    @(negedge clk);
    chk("ovf_data_held", data_valid_o, 1);
    chk("ovf_desc_held", desc_valid_o, 1);
    chk_cnt("ovf");
    rd_en = 1'b1;
    drain("ovf");
    drive(V(FAST_HEAD, 0, 1));
    drive(V(FAST_TAIL, 0, 1, 1, 2, 32, 3'b000));
    idle();
    drain("post_ovf");
    chk_cnt("post_ovf");

    // reset in the middle of a packet
    drive(V(FAST_HEAD, 0, 1));
    drive(V(FAST_BODY, 0, 1));
    @(posedge clk); #3;
    resetn = 1'b0;
    dataIn_valid_i = 1'b0;
    dq.delete();
    descq.delete();
    exp_pkt = 0; exp_drop = 0; exp_err = 0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    resetn = 1'b1;
    drive(V(FAST_HEAD, 0, 1));
    drive(V(FAST_BODY, 0, 1));
    drive(V(FAST_TAIL, 1, 1, 1, 3, 47, 3'b000));
    idle();
    drain("after_reset");
    chk_cnt("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nmis);
    $finish;
  end

endmodule
